// File: rtl/video_pkg.sv
// Shared video definitions: colour layout, idle levels and the control tag
// that travels alongside the sprite RAM read.
package video_pkg;

  localparam int COLOR_BITS = 9;
  localparam logic [COLOR_BITS-1:0] COLOR_BLACK               = '0;
  localparam logic [COLOR_BITS-1:0] COLOR_TRANSPARENT_DEFAULT = 9'b111_000_111;
  localparam logic SYNC_IDLE = 1'b1;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  typedef struct packed {
    logic active;
    logic print;
    logic hsync;
    logic vsync;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{active: 1'b0, print: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE};

  function automatic rgb_t rgb_split(input logic [COLOR_BITS-1:0] color);
    return rgb_t'(color);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a synchronous reset value; DEPTH cycles of
// latency, no flow control.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/color_output_module.sv
// Final pixel stage: sprite RAM read, transparency against a frame-latched
// background, RGB and syncs out MEM_LATENCY+2 clocks after input.
module color_output_module
  import video_pkg::*;
#(
  parameter int                    size_address = 17,
  parameter int                    color_bits   = COLOR_BITS,
  parameter int                    MEM_LATENCY  = 2,
  parameter logic [color_bits-1:0] TRANSPARENT  = COLOR_TRANSPARENT_DEFAULT
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [size_address-1:0] memory_address,
  input  logic                    printtingScreen,
  input  logic                    active_area,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic [size_address-1:0] mem_rd_addr,
  input  logic [color_bits-1:0]   mem_rdata,
  input  logic                    bg_wr,
  input  logic [color_bits-1:0]   bg_data,
  output logic [2:0]              R,
  output logic [2:0]              G,
  output logic [2:0]              B,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    frame_start,
  output logic [7:0]              frame_count
);

  ctrl_t                   w_ctrl_in;
  ctrl_t                   w_ctrl_dly;
  logic [color_bits-1:0]   w_pix;
  rgb_t                    w_rgb;

  logic [size_address-1:0] r_mem_rd_addr;
  logic [color_bits-1:0]   r_pix;
  logic                    r_hsync;
  logic                    r_vsync;
  logic                    r_vsync_prev;
  logic                    r_frame_start;
  logic [7:0]              r_frame_count;
  logic [color_bits-1:0]   r_bg_pending;
  logic [color_bits-1:0]   r_bg_current;

  assign w_ctrl_in = '{active: active_area, print: printtingScreen, hsync: hsync_in, vsync: vsync_in};

  // One extra stage beyond the RAM latency covers the address register.
  delay_line #(
    .WIDTH     ($bits(ctrl_t)),
    .DEPTH     (MEM_LATENCY + 1),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .i_clk (clk_pixel),
    .i_rst (reset),
    .i_dat (w_ctrl_in),
    .o_dat (w_ctrl_dly)
  );

  always_comb begin
    w_pix = COLOR_BLACK;
    if (w_ctrl_dly.active) begin
      if (!w_ctrl_dly.print || mem_rdata == TRANSPARENT) w_pix = r_bg_current;
      else                                               w_pix = mem_rdata;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_mem_rd_addr <= '0;
      r_pix         <= COLOR_BLACK;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
    end else begin
      r_mem_rd_addr <= memory_address;
      r_pix         <= w_pix;
      r_hsync       <= w_ctrl_dly.hsync;
      r_vsync       <= w_ctrl_dly.vsync;
    end
  end

  // Previous vsync resets low so a vsync already low at release is not a new frame.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_vsync_prev  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
      r_bg_pending  <= COLOR_BLACK;
      r_bg_current  <= COLOR_BLACK;
    end else begin
      r_vsync_prev  <= vsync_in;
      r_frame_start <= r_vsync_prev & ~vsync_in;
      if (bg_wr) r_bg_pending <= bg_data;
      if (r_frame_start) begin
        r_bg_current  <= bg_wr ? bg_data : r_bg_pending;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign w_rgb       = rgb_split(r_pix);
  assign R           = w_rgb.r;
  assign G           = w_rgb.g;
  assign B           = w_rgb.b;
  assign hsync_out   = r_hsync;
  assign vsync_out   = r_vsync;
  assign mem_rd_addr = r_mem_rd_addr;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_color_output_module.sv
// Scoreboard bench: directed pixels push hand-computed expectations tagged with
// the cycle they are due; a negedge monitor compares both latency variants.
module tb_color_output_module;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [16:0] memory_address;
  logic        printtingScreen, active_area, hsync_in, vsync_in, bg_wr;
  logic [8:0]  bg_data, mem_rdata, mem_rdata1;
  logic [16:0] mem_rd_addr, mem_rd_addr1;
  logic [2:0]  R, G, B, R1, G1, B1;
  logic        hs_o, vs_o, hs_o1, vs_o1, fs, fs1;
  logic [7:0]  fc, fc1;

  color_output_module dut (
    .clk_pixel(clk), .reset(reset), .memory_address(memory_address),
    .printtingScreen(printtingScreen), .active_area(active_area),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem_rd_addr(mem_rd_addr),
    .mem_rdata(mem_rdata), .bg_wr(bg_wr), .bg_data(bg_data),
    .R(R), .G(G), .B(B), .hsync_out(hs_o), .vsync_out(vs_o),
    .frame_start(fs), .frame_count(fc)
  );

  color_output_module #(.MEM_LATENCY(1)) dut1 (
    .clk_pixel(clk), .reset(reset), .memory_address(memory_address),
    .printtingScreen(printtingScreen), .active_area(active_area),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem_rd_addr(mem_rd_addr1),
    .mem_rdata(mem_rdata1), .bg_wr(bg_wr), .bg_data(bg_data),
    .R(R1), .G(G1), .B(B1), .hsync_out(hs_o1), .vsync_out(vs_o1),
    .frame_start(fs1), .frame_count(fc1)
  );

  // Sprite RAM models: two registered stages for the default part, one for dut1.
  logic [8:0] ram [256];
  logic [8:0] p1, p2, q1;
  always @(posedge clk) begin
    p1 <= ram[mem_rd_addr[7:0]];
    p2 <= p1;
    q1 <= ram[mem_rd_addr1[7:0]];
  end
  assign mem_rdata  = p2;
  assign mem_rdata1 = q1;

  typedef struct {
    int          kind;
    int          due;
    logic [16:0] val;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   vidx = 0;
  int   exp_fc;
  logic prev_vs;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] actual(input int k);
    case (k)
      0:       return {6'd0, hs_o, vs_o, R, G, B};
      1:       return {6'd0, hs_o1, vs_o1, R1, G1, B1};
      2:       return mem_rd_addr;
      3:       return {15'd0, fs, fs1};
      default: return {1'b0, fc, fc1};
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "rgb_sync_lat4";
      1:       return "rgb_sync_lat3";
      2:       return "mem_rd_addr";
      3:       return "frame_start";
      default: return "frame_count";
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        n_vec++;
        if (q[i].due != cyc || actual(q[i].kind) !== q[i].val) begin
          n_bad++;
          $display("FAIL %s at cycle %0d (due %0d): got %h, expected %h",
                   kname(q[i].kind), cyc, q[i].due, actual(q[i].kind), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int k, input int d, input logic [16:0] v);
    chk_t c;
    c.kind = k; c.due = d; c.val = v;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state();
    logic [63:0] got;
    logic [63:0] exp;
    got = {hs_o, vs_o, R, G, B, hs_o1, vs_o1, R1, G1, B1,
           mem_rd_addr, mem_rd_addr1, fs, fs1, fc, fc1};
    exp = {1'b1, 1'b1, 9'd0, 1'b1, 1'b1, 9'd0,
           17'd0, 17'd0, 1'b0, 1'b0, 8'd0, 8'd0};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_state at cycle %0d: got %h, expected %h", cyc, got, exp);
    end
  endtask

  // One pixel; ex is the hand-computed colour this pixel must produce.
  task automatic px(input logic p, input logic a, input logic hs, input logic vs,
                    input logic [8:0] rv, input logic [8:0] ex,
                    input logic bw, input logic [8:0] bd);
    int          e;
    logic [16:0] adr;
    adr = 17'h00010 + 17'(vidx % 200);
    vidx++;
    ram[adr[7:0]]   = rv;
    memory_address  = adr;
    printtingScreen = p;
    active_area     = a;
    hsync_in        = hs;
    vsync_in        = vs;
    bg_wr           = bw;
    bg_data         = bd;
    e = cyc + 1;
    if (prev_vs && !vs) exp_fc = (exp_fc + 1) % 256;
    push(0, e + 3, {6'd0, hs, vs, ex});
    push(1, e + 2, {6'd0, hs, vs, ex});
    push(2, e, adr);
    push(3, e, {15'd0, prev_vs & ~vs, prev_vs & ~vs});
    push(4, e + 1, {1'b0, 8'(exp_fc), 8'(exp_fc)});
    prev_vs = vs;
    step();
  endtask

  task automatic frame();
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
  endtask

  // Two reset cycles with hostile inputs (hsync low, vsync falling, bg write),
  // then the flushed black/sync-high window before fresh pixels emerge.
  task automatic do_reset();
    int r;
    r = cyc + 1;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].due >= r) q.delete(i);
    reset = 1'b1;
    active_area = 1'b1; printtingScreen = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
    bg_wr = 1'b1; bg_data = 9'h1FF;
    for (int d = r; d <= r + 1; d++) begin
      push(0, d, 17'h00600);
      push(1, d, 17'h00600);
      push(2, d, 17'h00000);
      push(3, d, 17'h00000);
      push(4, d, 17'h00000);
    end
    step();
    chk_reset_state();
    vsync_in = 1'b0;
    step();
    reset = 1'b0;
    for (int d = r + 2; d <= r + 4; d++) push(0, d, 17'h00600);
    for (int d = r + 2; d <= r + 3; d++) push(1, d, 17'h00600);
    push(4, r + 2, 17'h00000);
    prev_vs = 1'b0;
    exp_fc  = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 9'h000;
    memory_address = '0; printtingScreen = 0; active_area = 0;
    hsync_in = 1; vsync_in = 1; bg_wr = 0; bg_data = '0;
    prev_vs = 0; exp_fc = 0;
    do_reset();

    // Opaque, background-only and inactive pixels with background 0.
    px(1, 1, 1, 1, 9'b101_010_011, 9'b101_010_011, 0, 9'h000);
    px(0, 1, 1, 1, 9'h153, 9'h000, 0, 9'h000);
    px(1, 0, 1, 1, 9'h153, 9'h000, 0, 9'h000);
    px(0, 0, 1, 1, 9'h000, 9'h000, 1, 9'h0C0);
    frame();

    // Transparency against background 0C0.
    px(1, 1, 1, 1, 9'h1C7, 9'h0C0, 0, 9'h000);
    px(1, 0, 1, 1, 9'h1C7, 9'h000, 0, 9'h000);
    px(0, 1, 1, 1, 9'h0AA, 9'h0C0, 0, 9'h000);
    px(1, 1, 1, 1, 9'h1C6, 9'h1C6, 0, 9'h000);

    // Two writes in one frame: background holds until the next frame, last wins.
    px(0, 1, 1, 1, 9'h000, 9'h0C0, 1, 9'h007);
    px(0, 1, 1, 1, 9'h000, 9'h0C0, 0, 9'h000);
    px(0, 1, 1, 1, 9'h000, 9'h0C0, 1, 9'h038);
    px(0, 1, 1, 1, 9'h000, 9'h0C0, 0, 9'h000);
    px(0, 1, 1, 1, 9'h000, 9'h0C0, 0, 9'h000);
    frame();
    px(0, 1, 1, 1, 9'h000, 9'h038, 0, 9'h000);
    px(1, 1, 1, 1, 9'h1C7, 9'h038, 0, 9'h000);

    // Write coinciding with frame_start bypasses into the live background.
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 0, 9'h000, 9'h000, 1, 9'h1C0);
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    px(0, 1, 1, 1, 9'h000, 9'h1C0, 0, 9'h000);

    // Ten-cycle hsync pulse, checked per cycle on both latency variants.
    for (int i = 0; i < 10; i++) px(0, 1, 0, 1, 9'h000, 9'h1C0, 0, 9'h000);
    for (int i = 0; i < 4; i++)  px(0, 1, 1, 1, 9'h000, 9'h1C0, 0, 9'h000);

    // Run frame_count up to 255, then wrap on the 256th frame.
    while (exp_fc != 255) begin
      px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
      px(0, 0, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    end
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);

    // Active line interrupted by reset.
    for (int i = 0; i < 3; i++) px(1, 1, 1, 1, 9'h153, 9'h153, 0, 9'h000);
    px(0, 1, 1, 1, 9'h000, 9'h1C0, 0, 9'h000);
    do_reset();
    for (int i = 0; i < 3; i++) px(1, 1, 1, 0, 9'h153, 9'h153, 0, 9'h000);
    px(0, 1, 1, 0, 9'h000, 9'h000, 0, 9'h000);
    px(0, 0, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    frame();
    px(0, 1, 1, 1, 9'h000, 9'h000, 0, 9'h000);
    px(1, 1, 1, 1, 9'h1C7, 9'h000, 0, 9'h000);

    repeat (8) step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL expired wait: %0d expectations never came due", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule

// File: doc/color_output_module.md
# color_output_module

Final pixel stage of the video pipeline. Consumes the sprite-memory address and `printtingScreen` flag from the print stage, reads sprite colour data from the external sprite RAM, resolves transparency against a frame-latched background colour, and drives RGB plus delay-matched sync outputs to the VGA pins. It keeps video timing aligned with the memory read latency.

## Interface

Parameters:
- `size_address` — 17 — sprite memory address width.
- `color_bits` — 9 — pixel colour width, RGB 3-3-3 with R in the MSBs.
- `MEM_LATENCY` — 2 — clocks from `mem_rd_addr` valid to `mem_rdata` valid; legal range 1..4.
- `TRANSPARENT` — 9'b111_000_111 — colour code treated as see-through.

Ports:
- `clk_pixel` — in — 1 — pixel clock; the only clock.
- `reset` — in — 1 — synchronous, active-high.
- `memory_address` — in — size_address — address from the print stage.
- `printtingScreen` — in — 1 — high when the current pixel belongs to a sprite.
- `active_area` — in — 1 — visible-region flag.
- `hsync_in`, `vsync_in` — in — 1 each — active-low syncs from the timing generator.
- `mem_rd_addr` — out — size_address — registered sprite RAM read address.
- `mem_rdata` — in — color_bits — sprite RAM read data.
- `bg_wr` — in — 1 — one-cycle strobe that writes `bg_data`.
- `bg_data` — in — color_bits — new background colour.
- `R`, `G`, `B` — out — 3 each — pixel colour.
- `hsync_out`, `vsync_out` — out — 1 each — syncs delayed to match RGB.
- `frame_start` — out — 1 — one-cycle pulse on each `vsync_in` falling edge.
- `frame_count` — out — 8 — frames since reset; wraps 255→0.

## Operation

- **Stage A (cycle N).**
  - `mem_rd_addr <= memory_address`.
  - `active_area`, `printtingScreen` and the syncs enter a control delay line of depth `MEM_LATENCY+1`.
- **Stage B (cycle N+1+MEM_LATENCY).** `mem_rdata` and the delayed controls align. The output register loads one of:
  - delayed `active_area`=0 → RGB = 0.
  - active, `printtingScreen`=0 → RGB = `bg_current`.
  - active, `printtingScreen`=1, `mem_rdata`==TRANSPARENT → `bg_current`.
  - otherwise → `mem_rdata`.
  - `hsync_out`/`vsync_out` load in the same cycle from the delayed syncs.
- **Background double buffer.**
  - `bg_wr` writes `bg_pending`; with several writes in one frame, the last write wins.
  - `bg_current <= bg_pending` on `frame_start`.
  - If `bg_wr` and `frame_start` occur in the same cycle, `bg_data` bypasses directly into `bg_current`.
  - `bg_current` never changes mid-frame.
- **Frame detection.**
  - `vsync_in` is registered once; `frame_start` = previous 1 and current 0.
  - `frame_count` increments on `frame_start`.
- **Reset values.**
  - `mem_rd_addr`=0, `R`/`G`/`B`=0, `hsync_out`=`vsync_out`=1, `frame_start`=0, `frame_count`=0.
  - `bg_pending`=`bg_current`=0.
  - The control delay line fills with inactive values (active_area 0, printting 0, syncs 1).
- **Reset mid-frame.** The pipeline flushes. Outputs stay black with syncs high until valid inputs have propagated, `MEM_LATENCY+2` cycles after `reset` deasserts. No spurious `frame_start` pulse is generated.

## Timing

- Input to RGB/sync latency: exactly `MEM_LATENCY+2` clocks (4 at default).
- `frame_start` asserts 1 clock after the `vsync_in` falling edge. `frame_count` and `bg_current` update on the following clock edge.
- `frame_start` is not delay-matched to RGB; it is intended for software and register-bank use only.
- There is no backpressure: one pixel per clock, unconditionally.
- All outputs are registered; there are no combinational input→output paths.

## Structure

- **Shared package `video_pkg`:**
  - `COLOR_BITS`.
  - Constants `COLOR_BLACK`, `COLOR_TRANSPARENT_DEFAULT`.
  - Sync idle level `SYNC_IDLE = 1'b1`.
  - Function `rgb_split` (9-bit colour → R/G/B fields).
- **Sub-module `delay_line`:**
  - Parameterised width, depth and reset value.
  - Synchronous-reset shift register.
  - Used for the control path; a second instance can realign other tags later.

## Test plan

1. **Opaque pixel.** `reset` 1→0. Then `memory_address`=17'h00010, `printtingScreen`=1, `active_area`=1, RAM model returning 9'b101_010_011 after 2 clocks. → `R`=5, `G`=2, `B`=3 exactly 4 clocks after input. `mem_rd_addr`=17'h00010 after 1 clock.
2. **Transparent pixel.** `bg_current` = 9'h0C0 and RAM returns 9'b111_000_111. → RGB = 3/0/0. Repeat with `active_area`=0 → RGB = 0/0/0.
3. **Background double buffer.** Pulse `bg_wr` with `bg_data`=9'h007 mid-frame, then again with 9'h038 in the same frame. → Background unchanged until the next `vsync_in` fall. After it, background = 9'h038 and `frame_count` +1.
4. **Simultaneous write and frame start.** `bg_wr` (9'h1C0) in the same cycle as `frame_start`. → `bg_current`=9'h1C0 on the next clock.
5. **Sync alignment.** Drive a 10-cycle `hsync_in` low pulse. → `hsync_out` low pulse of identical 10-cycle width, delayed exactly 4 clocks. Repeat with `MEM_LATENCY`=1 → delay 3.
6. **Reset mid-frame and counter wrap.** Assert `reset` during an active line with `frame_count`=255 preloaded by 255 frames.
   - Before the reset: the 256th frame wraps `frame_count` to 0.
   - After `reset`: all outputs take their reset values; 4 black cycles with syncs high follow deassertion; no `frame_start` pulse.
